vlc_input_conditioner: RTL
==========================

// Module: vlc_input_conditioner
// PURPOSE
//  Front-end stage directly upstream of the vehicle lighting controller (tail-lamp sequencer).
//  Takes raw, asynchronous, bouncy dashboard switches (left stalk, right stalk, hazard button).
//  Produces clean, synchronous, mutually exclusive turn_left / turn_right / emergency levels
//  that drive the lamp sequencer's request inputs.
//  Also flags stalk conflicts and strobes whenever the request set changes.
// PARAMETERS
//  SYNC_STAGES      2   flops in each input synchroniser chain; must be >= 2
//  DEBOUNCE_CYCLES  16  consecutive stable synchronised samples needed to accept a new level; must be >= 1
//                       Counter width = $clog2(DEBOUNCE_CYCLES+1)
// PORTS
//  clk          in   1  system clock
//  rst          in   1  reset; synchronous, active-high
//  raw_left     in   1  left stalk switch, asynchronous, may bounce
//  raw_right    in   1  right stalk switch, asynchronous, may bounce
//  raw_hazard   in   1  hazard switch/button, asynchronous, may bounce
//  turn_left    out  1  registered left-turn request to lamp sequencer
//  turn_right   out  1  registered right-turn request to lamp sequencer
//  emergency    out  1  registered hazard request to lamp sequencer
//  conflict     out  1  registered; 1 while both debounced stalks are high
//  req_changed  out  1  1-cycle pulse on the edge where any of turn_left/turn_right/emergency changes
// BEHAVIOUR
//  Interface:
//  - One clock; reset is synchronous and active-high.
//  - While rst=1 at a clk edge, all of the following are cleared to 0: synchroniser flops,
//    debounce counters, stable levels, hazard latch, and every output.
//  - Reset mid-debounce discards any partial count.
//  Synchroniser:
//  - Each raw input passes through its own SYNC_STAGES-flop chain; there is no combinational path
//    from any raw_* input to any output.
//  Debounce (per channel; stable register and counter cnt):
//  - If sync == stable: cnt <= 0.
//  - Else if cnt == DEBOUNCE_CYCLES-1: stable <= sync, cnt <= 0.
//  - Else: cnt <= cnt + 1.
//  - A synchronised pulse shorter than DEBOUNCE_CYCLES cycles never reaches stable.
//  - DEBOUNCE_CYCLES=1 means stable follows sync with one cycle of delay.
//  Arbitration (output register stage):
//  - emergency  <= hazard_state | (left_s & right_s)
//  - turn_left  <= left_s & ~right_s & ~hazard_state
//  - turn_right <= right_s & ~left_s & ~hazard_state
//  - conflict   <= left_s & right_s
//  - Invariant: at most one of turn_left / turn_right / emergency is 1 in any cycle.
//  - req_changed <= (next {turn_left,turn_right,emergency}) != (current value).
//  - req_changed is 0 in reset and in the first cycle after reset.
//  Latency:
//  - Let edge k be the first clk edge that samples a new raw level held steady.
//  - Outputs change on edge k + SYNC_STAGES + DEBOUNCE_CYCLES.
//  - Simultaneous left/right edges resolve to emergency on the same edge.
//  - No intermediate turn_* pulse is emitted in that case.
// CONFIGURATION
//  Macro VLC_HAZARD_TOGGLE_EN.
//  Defined:
//  - raw_hazard is a momentary pushbutton.
//  - A 0->1 transition of debounced hazard toggles hazard_latch (registered rising-edge detect).
//  - Hazard path latency is +1 cycle versus the stalk paths.
//  - Holding the button produces exactly one toggle.
//  - hazard_state = hazard_latch.
//  Undefined:
//  - raw_hazard is a latching switch.
//  - hazard_state = debounced hazard level; no extra latency.
// TESTING
//  (SYNC_STAGES=2, DEBOUNCE_CYCLES=4 unless noted.)
//  1 Reset: all raw_*=1 and rst=1 for 3 edges -> all outputs 0 throughout, and 0 on the first
//    edge after rst drops.
//  2 Clean step: raw_left 0->1 sampled at edge k -> turn_left=1 from edge k+6, req_changed=1 for
//    exactly that one cycle; turn_right=emergency=0 throughout.
//  3 Bounce: raw_right high for 3 edges, then low -> all outputs and req_changed stay 0.
//  4 Conflict: left stable 1, then raw_right held 1 -> at edge +6: turn_left=0, emergency=1,
//    conflict=1, single req_changed pulse. Releasing right -> turn_left=1 6 edges later.
//  5 Hazard: press raw_hazard 10 cycles then release. With VLC_HAZARD_TOGGLE_EN: emergency=1
//    latched from edge k+7; a second press clears it. Without: emergency=1 from edge k+6, then 0
//    6 edges after release. Hazard overrides an active turn_left.
//  6 Reset mid-debounce: raw_left held 1, rst pulsed 1 cycle at edge k+4 -> turn_left stays 0,
//    then rises 6 edges after the first post-reset sampling edge.

Source files
------------

// File: rtl/vlc_input_conditioner.sv
// Dashboard switch conditioner: synchronise, debounce and arbitrate the stalk/hazard inputs
// into mutually exclusive lamp requests. Build option: VLC_HAZARD_TOGGLE_EN (pushbutton hazard).
module vlc_input_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_left,
  input  logic raw_right,
  input  logic raw_hazard,
  output logic turn_left,
  output logic turn_right,
  output logic emergency,
  output logic conflict,
  output logic req_changed
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // Channel bit order everywhere: {hazard, right, left}
  logic [2:0]    raw_vec;
  logic [2:0]    sync_chain [SYNC_STAGES];
  logic [2:0]    sync_lvl;
  logic [2:0]    stable;
  logic [CW-1:0] cnt [3];
  logic          hazard_state;

  assign raw_vec  = {raw_hazard, raw_right, raw_left};
  assign sync_lvl = sync_chain[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_chain[i] <= '0;
    end else begin
      sync_chain[0] <= raw_vec;
      for (int i = 1; i < SYNC_STAGES; i++) sync_chain[i] <= sync_chain[i-1];
    end
  end

  // A level is accepted only after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge clk) begin
    if (rst) begin
      stable <= '0;
      for (int ch = 0; ch < 3; ch++) cnt[ch] <= '0;
    end else begin
      for (int ch = 0; ch < 3; ch++) begin
        if (sync_lvl[ch] == stable[ch]) begin
          cnt[ch] <= '0;
        end else if (cnt[ch] == CNT_LAST) begin
          stable[ch] <= sync_lvl[ch];
          cnt[ch]    <= '0;
        end else begin
          cnt[ch] <= cnt[ch] + CW'(1);
        end
      end
    end
  end

`ifdef VLC_HAZARD_TOGGLE_EN
  logic hz_prev;
  logic hz_latch;

  always_ff @(posedge clk) begin
    if (rst) begin
      hz_prev  <= 1'b0;
      hz_latch <= 1'b0;
    end else begin
      hz_prev <= stable[2];
      if (stable[2] && !hz_prev) hz_latch <= ~hz_latch;
    end
  end

  assign hazard_state = hz_latch;
`else
  assign hazard_state = stable[2];
`endif

  logic nxt_left;
  logic nxt_right;
  logic nxt_emergency;
  logic nxt_conflict;

  always_comb begin
    nxt_emergency = hazard_state | (stable[0] & stable[1]);
    nxt_left      = stable[0] & ~stable[1] & ~hazard_state;
    nxt_right     = stable[1] & ~stable[0] & ~hazard_state;
    nxt_conflict  = stable[0] & stable[1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      turn_left   <= 1'b0;
      turn_right  <= 1'b0;
      emergency   <= 1'b0;
      conflict    <= 1'b0;
      req_changed <= 1'b0;
    end else begin
      turn_left   <= nxt_left;
      turn_right  <= nxt_right;
      emergency   <= nxt_emergency;
      conflict    <= nxt_conflict;
      req_changed <= {nxt_left, nxt_right, nxt_emergency} != {turn_left, turn_right, emergency};
    end
  end

endmodule
